// File: rtl/dmem_dumper.sv
// dmem_dumper -- debug-side bulk reader of the CPU data memory.
//
// On a start pulse the block walks every word of the data memory through the
// word-read port and streams each word out as four little-endian bytes
// (LSB first) over a valid/ready byte channel toward the debug UART.
//
// Optional feature (compile-time macro DMEM_DUMP_HEADER_EN):
//   when defined, two header bytes (8'hA5, then N[7:0]) precede the data.
//
// Parameters:
//   ADDR_WIDTH   byte-address width of the data memory; N = 2^(ADDR_WIDTH-2) words
//
// Ports:
//   clk          clock, all state on the rising edge
//   i_rst        synchronous active-high reset
//   i_start      one-cycle dump request, honoured only when idle
//   o_busy       high from the cycle after an accepted start until DONE is left
//   o_done       one-cycle pulse after the last byte and the final NEXT cycle
//   o_mem_raddr  word-aligned byte read address
//   o_mem_ren    memory read enable
//   o_mem_size   access size, constant word (2'b11)
//   i_mem_dout   memory read data
//   o_tx_data    byte to transmit
//   o_tx_valid   byte valid, held with stable data until accepted
//   i_tx_ready   transmitter accepts on o_tx_valid && i_tx_ready
module dmem_dumper #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_mem_raddr,
  output logic                  o_mem_ren,
  output logic [1:0]            o_mem_size,
  input  logic [31:0]           i_mem_dout,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready
);

  localparam int CW = ADDR_WIDTH - 2;
  localparam int N  = 1 << CW;
  localparam logic [CW-1:0] LAST_WORD = '1;
  localparam logic [7:0]    N_LO      = 8'(N);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
`ifdef DMEM_DUMP_HEADER_EN
    S_HDR     = 3'd1,
`endif
    S_READ    = 3'd2,
    S_CAPTURE = 3'd3,
    S_SEND    = 3'd4,
    S_NEXT    = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] word_cnt_q, word_cnt_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [31:0]   word_q, word_d;

  assign o_mem_size = 2'b11;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      word_cnt_q <= '0;
      byte_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      byte_idx_q <= byte_idx_d;
    end
  end

  // Captured word is pure data; it is only observed in SEND after a fresh capture.
  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

  // Every output is decoded from registered state, so i_tx_ready never reaches
  // o_tx_valid combinationally.
  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    byte_idx_d  = byte_idx_q;
    word_d      = word_q;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    o_mem_ren   = 1'b0;
    o_mem_raddr = '0;
    o_tx_valid  = 1'b0;
    o_tx_data   = '0;

    unique case (state_q)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          word_cnt_d = '0;
          byte_idx_d = '0;
`ifdef DMEM_DUMP_HEADER_EN
          state_d    = S_HDR;
`else
          state_d    = S_READ;
`endif
        end
      end

`ifdef DMEM_DUMP_HEADER_EN
      // byte_idx_q[0] selects magic byte (0) or word count (1).
      S_HDR: begin
        o_tx_valid = 1'b1;
        o_tx_data  = byte_idx_q[0] ? N_LO : 8'hA5;
        if (i_tx_ready) begin
          if (byte_idx_q[0]) begin
            byte_idx_d = '0;
            state_d    = S_READ;
          end else begin
            byte_idx_d = 2'd1;
          end
        end
      end
`endif

      S_READ: begin
        o_mem_ren   = 1'b1;
        o_mem_raddr = {word_cnt_q, 2'b00};
        state_d     = S_CAPTURE;
      end

      // The memory registers its output enable on the falling edge, so the
      // enable and address must be held through this second cycle.
      S_CAPTURE: begin
        o_mem_ren   = 1'b1;
        o_mem_raddr = {word_cnt_q, 2'b00};
        word_d      = i_mem_dout;
        state_d     = S_SEND;
      end

      S_SEND: begin
        o_tx_valid = 1'b1;
        o_tx_data  = word_q[{byte_idx_q, 3'b000} +: 8];
        if (i_tx_ready) begin
          if (byte_idx_q == 2'd3) begin
            state_d = S_NEXT;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end

      // Termination is decided before incrementing so the counter never wraps.
      S_NEXT: begin
        byte_idx_d = '0;
        if (word_cnt_q == LAST_WORD) begin
          state_d = S_DONE;
        end else begin
          word_cnt_d = word_cnt_q + CW'(1);
          state_d    = S_READ;
        end
      end

      S_DONE: begin
        o_done  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: doc/dmem_dumper.md
# dmem_dumper

Debug-side reader for the CPU data memory. On a start pulse it walks the whole data memory word by word through the memory read port and streams every word out as four little-endian bytes over a valid/ready byte channel feeding the debug UART transmitter. It sits between the debug unit and the data memory read port. It is the bulk consumer of the byte-lane memory's word-read path.

## Interface

Parameters:
- ADDR_WIDTH, 5, byte-address width of the data memory; word count N = 2^(ADDR_WIDTH-2).

Ports:
- clk  input  1  clock, all state on rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_start  input  1  one-cycle request to begin a dump; ignored unless idle.
- o_busy  output  1  high from the first cycle after an accepted start until DONE is left.
- o_done  output  1  one-cycle pulse after the last byte is accepted.
- o_mem_raddr  output  ADDR_WIDTH  byte read address, always word aligned (bits [1:0] = 0).
- o_mem_ren  output  1  memory read enable.
- o_mem_size  output  2  access size, constant 2'b11 (word).
- i_mem_dout  input  32  memory read data, valid one cycle after o_mem_ren rises with a stable address.
- o_tx_data  output  8  byte to transmit.
- o_tx_valid  output  1  o_tx_data is valid; held with data stable until accepted.
- i_tx_ready  input  1  transmitter accepts the byte when o_tx_valid && i_tx_ready on a rising edge.

## Operation

- States: IDLE, HDR (only with macro), READ, CAPTURE, SEND, NEXT, DONE.
- IDLE: outputs inactive. i_start=1 -> word counter = 0, byte index = 0; go to HDR if enabled, else READ.
- READ: o_mem_ren=1, o_mem_raddr = word_cnt << 2. Next state CAPTURE.
- CAPTURE: o_mem_ren stays 1 with the same address, because the memory gates its output with an enable registered on the falling edge. Latch i_mem_dout into a 32-bit word register at the end of the cycle, then go to SEND.
- SEND: o_mem_ren=0, o_tx_valid=1, o_tx_data = word_reg[8*byte_idx +: 8], starting with byte 0 (LSB first).
  - On handshake with byte_idx < 3: byte_idx increments and the state remains SEND.
  - On handshake with byte_idx = 3: go to NEXT.
- NEXT: byte_idx = 0.
  - If word_cnt = N-1: go to DONE.
  - Otherwise: word_cnt increments and the state goes to READ.
- DONE: o_done=1 for exactly one cycle, then IDLE. o_busy stays 1 in DONE.
- Word counter width is ADDR_WIDTH-2. It never wraps during a dump: termination is decided by comparing word_cnt to N-1 before incrementing.
- i_start is ignored in every state except IDLE, including DONE.
- i_tx_ready may toggle arbitrarily. o_tx_data must not change while o_tx_valid=1 and no handshake has occurred.
- Memory contents are read only; the block never asserts a write.

## Timing

- Reset values: o_busy=0, o_done=0, o_mem_ren=0, o_mem_raddr=0, o_mem_size=2'b11, o_tx_valid=0, o_tx_data=0. State is IDLE and all counters are 0.
- Reset mid-dump: the next cycle is IDLE with reset outputs, and the partial stream is abandoned. A start in the same cycle as i_rst is ignored.
- Start accepted at edge T (no header): READ during T+1, CAPTURE during T+2, first o_tx_valid during T+3.
- With i_tx_ready held 1, each word costs 7 cycles (READ, CAPTURE, 4×SEND, NEXT).
- Full dump cycles: 7·N + 1 (DONE). With the header, add 2 cycles.
- o_done rises the cycle after the final byte handshake plus NEXT, i.e. two edges after the last accept.
- All outputs are registered or decoded from state only; there are no combinational paths from i_tx_ready to o_tx_valid.

## Configuration

- DMEM_DUMP_HEADER_EN defined:
  - After start, HDR sends two bytes before any data: 8'hA5, then N[7:0]. Each byte uses the same valid/ready rule.
  - After the second byte is accepted, go to READ.
- DMEM_DUMP_HEADER_EN undefined: HDR does not exist, and the stream is exactly 4·N data bytes.

## Test plan

- Memory preloaded with word k = 32'h1000_0000 + k, ADDR_WIDTH=5, tx_ready always 1 -> 32 bytes: 00,00,00,10,01,00,00,10,…,07,00,00,10; o_done one pulse at cycle 57 after start; o_mem_raddr sequence 0,4,…,28.
- Same memory, i_tx_ready random 30% duty -> identical byte sequence. o_tx_data stable while valid and not ready; no byte lost or duplicated.
- i_start pulsed again mid-dump and during DONE -> ignored. Exactly one dump of 32 bytes and one o_done.
- i_rst asserted after the 10th byte -> the next cycle shows o_busy=0, o_tx_valid=0, o_mem_ren=0. A new start restarts at address 0 with byte 8'h00 of word 0.
- With DMEM_DUMP_HEADER_EN, ADDR_WIDTH=6 -> stream begins A5, 10, followed by 64 data bytes; o_done after 16·7+2+1 cycles.
- Check that o_mem_ren is high in both READ and CAPTURE with an unchanged address, and that the captured word equals memory contents (not zero) for the word at address 28 = 32'hDEAD_BEEF -> bytes EF, BE, AD, DE.
